// File: rtl/eh2_dccm_pkg.sv
// Shared widths, response entry type and pointer helper for the DCCM read controller.
package eh2_dccm_pkg;

  localparam int unsigned RSP_FIFO_DEPTH = 3;
  localparam int unsigned RSP_CNT_W      = 2;
  localparam int unsigned RSP_TAG_W      = 4;
  localparam int unsigned RSP_DATA_W     = 32;
  localparam int unsigned OCC_W          = 3;

  function automatic int unsigned bank_w(input int unsigned num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int unsigned idx_w(input int unsigned index_depth);
    return $clog2(index_depth);
  endfunction

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic [RSP_TAG_W-1:0]  tag;
    logic                  err;
  } rsp_entry_t;

  // Pointers count 0,1,2,0,... so a 3-entry ring needs no power-of-two depth.
  function automatic logic [RSP_CNT_W-1:0] ptr_inc(input logic [RSP_CNT_W-1:0] ptr);
    return (ptr == RSP_CNT_W'(RSP_FIFO_DEPTH - 1)) ? '0 : ptr + RSP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eh2_dccm_rsp_fifo.sv
// Three-entry response FIFO; head entry and occupancy come straight from registers.
module eh2_dccm_rsp_fifo
  import eh2_dccm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 push_i,
  input  rsp_entry_t           push_entry_i,
  input  logic                 pop_i,
  output rsp_entry_t           head_o,
  output logic [RSP_CNT_W-1:0] count_o
);

  rsp_entry_t           mem_q [RSP_FIFO_DEPTH];
  logic [RSP_CNT_W-1:0] wr_ptr_q;
  logic [RSP_CNT_W-1:0] rd_ptr_q;
  logic [RSP_CNT_W-1:0] count_q;
  logic [RSP_CNT_W-1:0] count_d;

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + RSP_CNT_W'(1);
      2'b01:   count_d = count_q - RSP_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/eh2_lsu_dccm_rd_ctl.sv
// DCCM read controller: banked read strobe, next-cycle capture, in-order 3-deep response queue.
// Optional DCCM_RD_PARITY_EN adds an even-parity bit per RAM word and reports it on rsp_err.
module eh2_lsu_dccm_rd_ctl
  import eh2_dccm_pkg::*;
#(
  parameter  int unsigned DCCM_INDEX_DEPTH = 8192,
  parameter  int unsigned DCCM_NUM_BANKS   = 2,
  parameter  int unsigned DATA_WIDTH       = RSP_DATA_W,
  localparam int unsigned BANK_W           = bank_w(DCCM_NUM_BANKS),
  localparam int unsigned IDX_W            = idx_w(DCCM_INDEX_DEPTH),
`ifdef DCCM_RD_PARITY_EN
  localparam int unsigned RAM_W            = DATA_WIDTH + 1
`else
  localparam int unsigned RAM_W            = DATA_WIDTH
`endif
)(
  input  logic                              clk,
  input  logic                              rst_l,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [BANK_W+IDX_W-1:0]           req_addr,
  input  logic [RSP_TAG_W-1:0]              req_tag,
  output logic [DCCM_NUM_BANKS-1:0]         ram_rd_en,
  output logic [IDX_W-1:0]                  ram_rd_addr,
  input  logic [DCCM_NUM_BANKS*RAM_W-1:0]   ram_rd_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [RSP_TAG_W-1:0]              rsp_tag,
  output logic                              rsp_err
);

  logic [BANK_W-1:0]    req_bank;
  logic                 accept;
  logic                 pop;
  logic                 inflight_q;
  logic [BANK_W-1:0]    bank_q;
  logic [RSP_TAG_W-1:0] tag_q;
  logic                 req_ready_q;
  logic                 req_ready_d;
  logic [OCC_W-1:0]     occ_nxt;
  logic [RAM_W-1:0]     cap_word;
  rsp_entry_t           cap_entry;
  rsp_entry_t           head;
  logic [RSP_CNT_W-1:0] fifo_count;

  assign req_bank    = req_addr[BANK_W-1:0];
  assign ram_rd_addr = req_addr[BANK_W +: IDX_W];
  assign accept      = req_valid & req_ready_q;
  assign req_ready   = req_ready_q;

  always_comb begin
    ram_rd_en = '0;
    if (accept) begin
      ram_rd_en[req_bank] = 1'b1;
    end
  end

  // Select the bank strobed last cycle and build the queued response.
  always_comb begin
    cap_word = '0;
    for (int unsigned b = 0; b < DCCM_NUM_BANKS; b++) begin
      if (bank_q == BANK_W'(b)) begin
        cap_word = ram_rd_data[b*RAM_W +: RAM_W];
      end
    end
  end

  always_comb begin
    cap_entry      = '0;
    cap_entry.data = RSP_DATA_W'(cap_word[DATA_WIDTH-1:0]);
    cap_entry.tag  = tag_q;
`ifdef DCCM_RD_PARITY_EN
    cap_entry.err  = ^cap_word;
`else
    cap_entry.err  = 1'b0;
`endif
  end

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;

  // Ready is registered from next-cycle occupancy so rsp_ready never reaches it combinationally.
  always_comb begin
    occ_nxt     = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop) + OCC_W'(accept);
    req_ready_d = (occ_nxt < OCC_W'(RSP_FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      inflight_q  <= 1'b0;
      bank_q      <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      inflight_q  <= accept;
      req_ready_q <= req_ready_d;
      if (accept) begin
        bank_q <= req_bank;
        tag_q  <= req_tag;
      end
    end
  end

  eh2_dccm_rsp_fifo u_rsp_fifo (
    .clk          (clk),
    .rst_l        (rst_l),
    .push_i       (inflight_q),
    .push_entry_i (cap_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign rsp_data = DATA_WIDTH'(head.data);
  assign rsp_tag  = head.tag;
  assign rsp_err  = head.err;

endmodule

// File: tb/tb_eh2_lsu_dccm_rd_ctl.sv
// Bench for eh2_lsu_dccm_rd_ctl: directed vector table, corner sequences and a random run
// checked against a request/response queue model.
module tb_eh2_lsu_dccm_rd_ctl;

  localparam int NB = 2;
  localparam int IW = 13;
  localparam int AW = 14;
`ifdef DCCM_RD_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  logic              clk;
  logic              rst_l;
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic [3:0]        req_tag;
  logic [NB-1:0]     ram_rd_en;
  logic [IW-1:0]     ram_rd_addr;
  logic [NB*RAM_W-1:0] ram_rd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [3:0]        rsp_tag;
  logic              rsp_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic corrupt;

  eh2_lsu_dccm_rd_ctl dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_tag     (req_tag),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word address a holds a+124 in the low region, a hash above it.
  function automatic logic [31:0] word_of(input int unsigned a);
    if (a < 1024) return 32'(a + 124);
    return 32'(a) * 32'h9E37_79B1;
  endfunction

  function automatic logic [RAM_W-1:0] ram_word(input int unsigned a, input logic bad);
    logic [31:0] d;
    d = word_of(a);
`ifdef DCCM_RD_PARITY_EN
    return {(^d) ^ bad, d};
`else
    if (bad) return d;
    return d;
`endif
  endfunction

  // Bank RAMs with one-cycle read latency.
  logic [RAM_W-1:0] rd_q [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_rd_en[b]) rd_q[b] <= ram_word(int'(ram_rd_addr) * NB + b, corrupt);
    end
  end
  always_comb begin
    ram_rd_data = '0;
    for (int b = 0; b < NB; b++) ram_rd_data[b*RAM_W +: RAM_W] = rd_q[b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: every accepted request, in order, with the cycle it was accepted.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          acc_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic step(input logic v, input int unsigned a, input logic [3:0] t,
                      input logic rr, input logic bad = 1'b0);
    logic acc;
    logic do_pop;
    logic exp_valid;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_addr  = AW'(a);
    req_tag   = t;
    rsp_ready = rr;
    corrupt   = bad;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_q.size() < 3));
    acc = v && req_ready;
    chk("ram_rd_en", 64'(ram_rd_en), acc ? 64'(1) << (a % NB) : 64'(0));
    if (acc) chk("ram_rd_addr", 64'(ram_rd_addr), 64'(a / NB));
    exp_valid = (exp_q.size() > 0) && (cyc - exp_q[0].acc_cyc >= 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    do_pop = 1'b0;
    if (rsp_valid && exp_q.size() > 0) begin
      chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
      chk("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
      chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
      do_pop = rr;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (acc) begin
      e.data = word_of(a);
      e.tag  = t;
`ifdef DCCM_RD_PARITY_EN
      e.err  = bad;
`else
      e.err  = 1'b0;
`endif
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_ram_rd_en"}, 64'(ram_rd_en), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_rsp_tag"}, 64'(rsp_tag), 64'(0));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
  endtask

  typedef struct {
    logic        v;
    int unsigned a;
    logic [3:0]  t;
    logic        rr;
    logic        e_rdy;
    logic [1:0]  e_en;
    logic        e_vld;
    logic [31:0] e_data;
    logic [3:0]  e_tag;
  } vec_t;

  function automatic vec_t mk(input logic v, input int unsigned a, input logic [3:0] t,
                              input logic rr, input logic e_rdy, input logic [1:0] e_en,
                              input logic e_vld, input logic [31:0] e_data, input logic [3:0] e_tag);
    vec_t r;
    r.v = v; r.a = a; r.t = t; r.rr = rr;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_vld = e_vld; r.e_data = e_data; r.e_tag = e_tag;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[19];
    // single read, back-to-back, then backpressure with four requests
    vecs[0]  = mk(1,  6, 5, 1,  1, 2'b01, 0,   0, 0);
    vecs[1]  = mk(0,  0, 0, 1,  1, 2'b00, 0,   0, 0);
    vecs[2]  = mk(0,  0, 0, 1,  1, 2'b00, 1, 130, 5);
    vecs[3]  = mk(0,  0, 0, 1,  1, 2'b00, 0,   0, 0);
    vecs[4]  = mk(1,  6, 1, 1,  1, 2'b01, 0,   0, 0);
    vecs[5]  = mk(1,  7, 2, 1,  1, 2'b10, 0,   0, 0);
    vecs[6]  = mk(0,  0, 0, 1,  1, 2'b00, 1, 130, 1);
    vecs[7]  = mk(0,  0, 0, 1,  1, 2'b00, 1, 131, 2);
    vecs[8]  = mk(0,  0, 0, 1,  1, 2'b00, 0,   0, 0);
    vecs[9]  = mk(1,  8, 3, 0,  1, 2'b01, 0,   0, 0);
    vecs[10] = mk(1,  9, 4, 0,  1, 2'b10, 0,   0, 0);
    vecs[11] = mk(1, 10, 5, 0,  1, 2'b01, 1, 132, 3);
    vecs[12] = mk(1, 11, 6, 0,  0, 2'b00, 1, 132, 3);
    vecs[13] = mk(1, 11, 6, 0,  0, 2'b00, 1, 132, 3);
    vecs[14] = mk(1, 11, 6, 1,  0, 2'b00, 1, 132, 3);
    vecs[15] = mk(1, 11, 6, 1,  1, 2'b10, 1, 133, 4);
    vecs[16] = mk(0,  0, 0, 1,  1, 2'b00, 1, 134, 5);
    vecs[17] = mk(0,  0, 0, 1,  1, 2'b00, 1, 135, 6);
    vecs[18] = mk(0,  0, 0, 1,  1, 2'b00, 0,   0, 0);

    rst_l = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; rsp_ready = 1'b0; corrupt = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].t, vecs[i].rr);
      chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d_rd_en", i), 64'(ram_rd_en), 64'(vecs[i].e_en));
      chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("tbl%0d_data", i), 64'(rsp_data), 64'(vecs[i].e_data));
        chk($sformatf("tbl%0d_tag", i), 64'(rsp_tag), 64'(vecs[i].e_tag));
      end
    end

    // Push and pop in one cycle while two entries are held.
    step(1, 12, 9, 0);
    step(1, 13, 10, 0);
    step(1, 14, 11, 0);
    step(0, 0, 0, 1);
    chk("pp_full_ready", 64'(req_ready), 64'(0));
    step(0, 0, 0, 0);
    chk("pp_count_held", 64'(req_ready), 64'(1));
    chk("pp_order", 64'(rsp_data), 64'(137));
    repeat (3) step(0, 0, 0, 1);

`ifdef DCCM_RD_PARITY_EN
    step(1, 106, 1, 1, 1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("par_bad_err", 64'(rsp_err), 64'(1));
    chk("par_bad_data", 64'(rsp_data), 64'(230));
    step(1, 106, 2, 1, 1'b0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("par_good_err", 64'(rsp_err), 64'(0));
    chk("par_good_data", 64'(rsp_data), 64'(230));
`endif

    // Reset with two reads outstanding.
    step(1, 20, 7, 1);
    step(1, 21, 8, 1);
    @(negedge clk);
    rst_l = 1'b0; req_valid = 1'b0;
    #1;
    chk_reset_outputs("mid");
    cyc++;
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    chk("mid_rel_valid", 64'(rsp_valid), 64'(0));
    cyc++;
    exp_q.delete();
    step(0, 0, 0, 1);
    chk("mid_ready_after", 64'(req_ready), 64'(1));
    repeat (4) step(0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom_range(0, (1 << AW) - 1), 4'($urandom),
           ($urandom % 10) < 7);
    end
    repeat (6) step(0, 0, 0, 1);
    chk("drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
